imem_loader: RTL and testbench

Program loader for the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles each group of four bytes into a 32-bit instruction word. It writes each word into the instruction memory at consecutive byte addresses 0, 4, 8, … and holds the CPU in `o_Busy` while loading. It sits between the host/UART byte source and the instruction memory's write port, and stops on the halt word 32'hFC000000 or when memory is full.

---
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_loader.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Purpose  : Byte-stream handshake plus instruction-memory write port.
// Revision : 1.0
// ============================================================================
interface imem_loader_if;
    logic [7:0]  i_Byte;
    logic        i_Valid;
    logic        o_Ready;
    logic        o_We;
    logic [31:0] o_Addr;
    logic [31:0] o_Data;

    // Loader side: consumes bytes, drives the memory write port.
    modport slave (
        input  i_Byte,
        input  i_Valid,
        output o_Ready,
        output o_We,
        output o_Addr,
        output o_Data
    );

    // Byte source / memory side.
    modport master (
        output i_Byte,
        output i_Valid,
        input  o_Ready,
        input  o_We,
        input  o_Addr,
        input  o_Data
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Packs a big-endian byte stream into 32-bit words and writes them
//            to instruction memory until the halt word or memory is full.
//            Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int SIZE_IM = 128,
    parameter int CW      = $clog2(SIZE_IM) + 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          start,
    imem_loader_if.slave       bus,
    output logic               o_Busy,
    output logic               o_Done,
    output logic               o_Error,
    output logic [CW-1:0]      o_WordCount
);

    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE} state_t;
`endif

    state_t         state, state_nx;
    logic [23:0]    shreg, shreg_nx;
    logic [1:0]     byte_idx, byte_idx_nx;
    logic [CW-1:0]  count, count_nx;
    logic [31:0]    addr, addr_nx;
    logic [31:0]    data, data_nx;
    logic           we, we_nx;
    logic           ready, ready_nx;
    logic           busy, busy_nx;
    logic           done, done_nx;
    logic           error, error_nx;
    logic           accept;
    logic [31:0]    full_word;
    logic [CW-1:0]  count_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]    csum, csum_nx;
`endif

    assign accept    = ready && bus.i_Valid;
    assign full_word = {shreg, bus.i_Byte};
    assign count_inc = count + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_idx <= '0;
            count    <= '0;
            addr     <= '0;
            data     <= '0;
            we       <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            byte_idx <= byte_idx_nx;
            count    <= count_nx;
            addr     <= addr_nx;
            data     <= data_nx;
            we       <= we_nx;
            ready    <= ready_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            error    <= error_nx;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum_nx;
`endif
        end
    end

    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        byte_idx_nx = byte_idx;
        count_nx    = count;
        addr_nx     = addr;
        data_nx     = data;
        we_nx       = 1'b0;
        done_nx     = done;
        error_nx    = error;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_nx     = csum;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx    = COLLECT;
                    byte_idx_nx = '0;
                    count_nx    = '0;
                    addr_nx     = '0;
                    done_nx     = 1'b0;
                    error_nx    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_nx     = '0;
`endif
                end
            end
            COLLECT: begin
                if (accept) begin
                    shreg_nx    = full_word[23:0];
                    byte_idx_nx = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state_nx = WRITE;
                        we_nx    = 1'b1;
                        data_nx  = full_word;
                        addr_nx  = 32'(count) << 2;
                    end
                end
            end
            WRITE: begin
                count_nx = count_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_nx  = csum ^ data;
`endif
                if (data == HALT_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nx = CHECK;
`else
                    state_nx = DONE;
                    done_nx  = 1'b1;
`endif
                end else if (count_inc == CW'(SIZE_IM)) begin
                    // Memory full without a terminator: truncated load.
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    error_nx = 1'b1;
                end else begin
                    state_nx = COLLECT;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    shreg_nx    = full_word[23:0];
                    byte_idx_nx = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        if (full_word != csum) begin
                            error_nx = 1'b1;
                        end
                    end
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Handshake/status outputs are registered from the next state.
    always_comb begin
        ready_nx = 1'b0;
        busy_nx  = 1'b0;
        case (state_nx)
            COLLECT: begin
                ready_nx = 1'b1;
                busy_nx  = 1'b1;
            end
            WRITE:   busy_nx = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                ready_nx = 1'b1;
                busy_nx  = 1'b1;
            end
`endif
            default: begin
                ready_nx = 1'b0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    assign bus.o_Ready  = ready;
    assign bus.o_We     = we;
    assign bus.o_Addr   = addr;
    assign bus.o_Data   = data;
    assign o_Busy       = busy;
    assign o_Done       = done;
    assign o_Error      = error;
    assign o_WordCount  = count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed bench for imem_loader (depth 128 and depth 4 instances).
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_tb = 1'b0;
    logic       sel = 1'b0;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_byte = 8'h00;

    always #5 clk = ~clk;

    imem_loader_if ifa();
    imem_loader_if ifb();

    logic       busy_a, done_a, err_a;
    logic [7:0] cnt_a;
    logic       busy_b, done_b, err_b;
    logic [2:0] cnt_b;
    logic       start_a, start_b;

    assign ifa.i_Byte  = tb_byte;
    assign ifb.i_Byte  = tb_byte;
    assign ifa.i_Valid = tb_valid & ~sel;
    assign ifb.i_Valid = tb_valid & sel;
    assign start_a     = start_tb & ~sel;
    assign start_b     = start_tb & sel;

    imem_loader #(.SIZE_IM(128)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .bus(ifa),
        .o_Busy(busy_a), .o_Done(done_a), .o_Error(err_a), .o_WordCount(cnt_a)
    );

    imem_loader #(.SIZE_IM(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .bus(ifb),
        .o_Busy(busy_b), .o_Done(done_b), .o_Error(err_b), .o_WordCount(cnt_b)
    );

    logic       cur_ready, cur_done, cur_error, cur_busy;
    logic [7:0] cur_count;
    assign cur_ready = sel ? ifb.o_Ready : ifa.o_Ready;
    assign cur_done  = sel ? done_b : done_a;
    assign cur_error = sel ? err_b : err_a;
    assign cur_busy  = sel ? busy_b : busy_a;
    assign cur_count = sel ? {5'd0, cnt_b} : cnt_a;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wa_a[$];
    logic [31:0] wd_a[$];
    logic [31:0] wa_b[$];
    logic [31:0] wd_b[$];
    logic        viol = 1'b0;

    always @(negedge clk) begin
        if (ifa.o_We) begin
            wa_a.push_back(ifa.o_Addr);
            wd_a.push_back(ifa.o_Data);
        end
        if (ifb.o_We) begin
            wa_b.push_back(ifb.o_Addr);
            wd_b.push_back(ifb.o_Data);
        end
        if ((ifa.o_We && ifa.o_Ready) || (ifb.o_We && ifb.o_Ready)) viol = 1'b1;
    end

    // All tasks enter and leave on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        tb_valid = 1'b0;
        repeat (gap) @(negedge clk);
        tb_byte  = b;
        tb_valid = 1'b1;
        for (int t = 0; t < 100 && !cur_ready; t++) @(negedge clk);
        vectors++;
        if (cur_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL handshake_timeout: o_Ready=%b required 1", cur_ready);
        end
        @(negedge clk);
        tb_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(tmp[31:24], rnd ? int'($urandom_range(1, 3)) : 0);
            tmp = tmp << 8;
        end
    endtask

    task automatic do_start();
        start_tb = 1'b1;
        @(negedge clk);
        start_tb = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 200 && !cur_done; t++) @(negedge clk);
        vectors++;
        if (cur_done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: o_Done=%b required 1", cur_done);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        vectors += 8;
        if (ifa.o_Ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", ifa.o_Ready); end
        if (ifa.o_We !== 1'b0)    begin miscompares++; $display("FAIL rst_we: got %b want 0", ifa.o_We); end
        if (ifa.o_Addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", ifa.o_Addr); end
        if (ifa.o_Data !== 32'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0", ifa.o_Data); end
        if (busy_a !== 1'b0)      begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        if (done_a !== 1'b0)      begin miscompares++; $display("FAIL rst_done: got %b want 0", done_a); end
        if (err_a !== 1'b0)       begin miscompares++; $display("FAIL rst_error: got %b want 0", err_a); end
        if (cnt_a !== 8'd0)       begin miscompares++; $display("FAIL rst_count: got %0d want 0", cnt_a); end
    endtask

    task automatic test_basic(input bit rnd);
        sel = 1'b0;
        wa_a.delete(); wd_a.delete(); viol = 1'b0;
        do_start();
        vectors += 2;
        if (busy_a !== 1'b1)      begin miscompares++; $display("FAIL start_busy: got %b want 1", busy_a); end
        if (ifa.o_Ready !== 1'b1) begin miscompares++; $display("FAIL start_ready: got %b want 1", ifa.o_Ready); end
        send_word(32'h208C_0004, rnd);
        vectors += 4;
        if (ifa.o_We !== 1'b1)           begin miscompares++; $display("FAIL write_we: got %b want 1", ifa.o_We); end
        if (ifa.o_Ready !== 1'b0)        begin miscompares++; $display("FAIL write_ready: got %b want 0", ifa.o_Ready); end
        if (ifa.o_Addr !== 32'h0)        begin miscompares++; $display("FAIL write_addr: got %h want 0", ifa.o_Addr); end
        if (ifa.o_Data !== 32'h208C0004) begin miscompares++; $display("FAIL write_data: got %h want 208c0004", ifa.o_Data); end
        @(negedge clk);
        vectors++;
        if (cnt_a !== 8'd1) begin miscompares++; $display("FAIL count_after_write: got %0d want 1", cnt_a); end
        send_word(32'hFC00_0000, rnd);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hDC8C_0004, rnd);
`endif
        wait_done();
        @(negedge clk);
        vectors += 8;
        if (wa_a.size() != 2) begin
            miscompares++; $display("FAIL basic_nwrites: got %0d want 2", wa_a.size());
        end else begin
            if (wa_a[0] !== 32'h0)        begin miscompares++; $display("FAIL basic_addr0: got %h want 0", wa_a[0]); end
            if (wd_a[0] !== 32'h208C0004) begin miscompares++; $display("FAIL basic_data0: got %h want 208c0004", wd_a[0]); end
            if (wa_a[1] !== 32'h4)        begin miscompares++; $display("FAIL basic_addr1: got %h want 4", wa_a[1]); end
            if (wd_a[1] !== 32'hFC000000) begin miscompares++; $display("FAIL basic_data1: got %h want fc000000", wd_a[1]); end
        end
        if (cnt_a !== 8'd2)  begin miscompares++; $display("FAIL basic_count: got %0d want 2", cnt_a); end
        if (err_a !== 1'b0)  begin miscompares++; $display("FAIL basic_error: got %b want 0", err_a); end
        if (busy_a !== 1'b0) begin miscompares++; $display("FAIL basic_busy: got %b want 0", busy_a); end
        if (viol !== 1'b0)   begin miscompares++; $display("FAIL we_with_ready: got %b want 0", viol); end
    endtask

    task automatic test_truncate();
        logic [31:0] words [4];
        words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h01020304};
        sel = 1'b1;
        wa_b.delete(); wd_b.delete();
        do_start();
        for (int i = 0; i < 4; i++) send_word(words[i], 1'b0);
        wait_done();
        tb_byte = 8'h55; tb_valid = 1'b1;
        repeat (10) @(negedge clk);
        tb_valid = 1'b0;
        vectors += 4;
        if (wa_b.size() != 4) begin
            miscompares++; $display("FAIL trunc_nwrites: got %0d want 4", wa_b.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors += 2;
                if (wa_b[i] !== 32'(i * 4)) begin miscompares++; $display("FAIL trunc_addr%0d: got %h want %h", i, wa_b[i], i * 4); end
                if (wd_b[i] !== words[i])   begin miscompares++; $display("FAIL trunc_data%0d: got %h want %h", i, wd_b[i], words[i]); end
            end
        end
        if (err_b !== 1'b1)       begin miscompares++; $display("FAIL trunc_error: got %b want 1", err_b); end
        if (cnt_b !== 3'd4)       begin miscompares++; $display("FAIL trunc_count: got %0d want 4", cnt_b); end
        if (ifb.o_Ready !== 1'b0) begin miscompares++; $display("FAIL trunc_ready: got %b want 0", ifb.o_Ready); end
        sel = 1'b0;
    endtask

    task automatic test_reset_midload();
        sel = 1'b0;
        wa_a.delete(); wd_a.delete();
        do_start();
        send_word(32'h0102_0304, 1'b0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset();
        vectors += 6;
        if (ifa.o_Ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 0", ifa.o_Ready); end
        if (ifa.o_Addr !== 32'h0) begin miscompares++; $display("FAIL mid_rst_addr: got %h want 0", ifa.o_Addr); end
        if (ifa.o_Data !== 32'h0) begin miscompares++; $display("FAIL mid_rst_data: got %h want 0", ifa.o_Data); end
        if (busy_a !== 1'b0)      begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", busy_a); end
        if (cnt_a !== 8'd0)       begin miscompares++; $display("FAIL mid_rst_count: got %0d want 0", cnt_a); end
        if (done_a !== 1'b0)      begin miscompares++; $display("FAIL mid_rst_done: got %b want 0", done_a); end
        wa_a.delete(); wd_a.delete();
        do_start();
        send_word(32'hAABB_CCDD, 1'b0);
        @(negedge clk);
        vectors++;
        if (wa_a.size() != 1 || wa_a[0] !== 32'h0 || wd_a[0] !== 32'hAABBCCDD) begin
            miscompares++;
            $display("FAIL mid_rst_rewrite: got n=%0d addr=%h data=%h want n=1 addr=0 data=aabbccdd",
                     wa_a.size(), (wa_a.size() > 0) ? wa_a[0] : 32'hx, (wd_a.size() > 0) ? wd_a[0] : 32'hx);
        end
        do_reset();
    endtask

    task automatic test_start_ignored();
        sel = 1'b0;
        wa_a.delete(); wd_a.delete();
        do_start();
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        do_start();
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        @(negedge clk);
        do_start();
        send_word(32'hFC00_0000, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hEE34_5678, 1'b0);
`endif
        wait_done();
        @(negedge clk);
        vectors += 3;
        if (wa_a.size() != 2) begin
            miscompares++; $display("FAIL ign_nwrites: got %0d want 2", wa_a.size());
        end else begin
            if (wd_a[0] !== 32'h12345678) begin miscompares++; $display("FAIL ign_data0: got %h want 12345678", wd_a[0]); end
            if (wa_a[1] !== 32'h4)        begin miscompares++; $display("FAIL ign_addr1: got %h want 4", wa_a[1]); end
        end
        if (cnt_a !== 8'd2) begin miscompares++; $display("FAIL ign_count: got %0d want 2", cnt_a); end
        wa_a.delete(); wd_a.delete();
        do_start();
        vectors += 3;
        if (done_a !== 1'b0) begin miscompares++; $display("FAIL restart_done: got %b want 0", done_a); end
        if (err_a !== 1'b0)  begin miscompares++; $display("FAIL restart_error: got %b want 0", err_a); end
        if (busy_a !== 1'b1) begin miscompares++; $display("FAIL restart_busy: got %b want 1", busy_a); end
        send_word(32'hCAFE_F00D, 1'b0);
        @(negedge clk);
        vectors++;
        if (wa_a.size() != 1 || wa_a[0] !== 32'h0 || wd_a[0] !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL restart_write: got n=%0d addr=%h data=%h want n=1 addr=0 data=cafef00d",
                     wa_a.size(), (wa_a.size() > 0) ? wa_a[0] : 32'hx, (wd_a.size() > 0) ? wd_a[0] : 32'hx);
        end
        do_reset();
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum(input logic [31:0] sum, input logic exp_err);
        sel = 1'b0;
        wa_a.delete(); wd_a.delete();
        do_start();
        send_word(32'h0000_0001, 1'b0);
        send_word(32'hFC00_0000, 1'b0);
        send_word(sum, 1'b0);
        wait_done();
        @(negedge clk);
        vectors += 3;
        if (err_a !== exp_err) begin miscompares++; $display("FAIL csum_error: got %b want %b", err_a, exp_err); end
        if (wa_a.size() != 2)  begin miscompares++; $display("FAIL csum_nwrites: got %0d want 2", wa_a.size()); end
        if (cnt_a !== 8'd2)    begin miscompares++; $display("FAIL csum_count: got %0d want 2", cnt_a); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic(1'b0);
        test_reset();
        test_basic(1'b1);
        test_truncate();
        test_reset_midload();
        test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum(32'hFC00_0001, 1'b0);
        test_checksum(32'hFC00_0000, 1'b1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
